// File: rtl/tcbm_device_link.sv
`default_nettype none
// ============================================================================
// Module   : tcbm_device_link
// Brief    : Device side of the TCBM dav_n/ack_n parallel handshake, with a
//            4-deep receive FIFO and a single-byte transmit offer.
// Revision : 1.0 - initial release
// ============================================================================
module tcbm_device_link #(
    parameter int SETUP_CYCLES = 2,
    parameter int TIMEOUT      = 65535
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dav_n,
    output logic       ack_n,
    input  logic [7:0] pa_in,
    output logic [7:0] pa_out,
    output logic       pa_oe,
    output logic [1:0] status,
    input  logic       dir,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic [1:0] tx_status,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_HOLD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [3:0]  c_setup_last   = 4'(SETUP_CYCLES - 1);
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_dav_meta;
    logic        r_dav_s;
    logic [7:0]  r_pa_meta;
    logic [7:0]  r_pa_s;
    logic        r_dir;
    logic [3:0]  r_setup_cnt;
    logic [15:0] r_hold_cnt;
    logic        r_wait_high;
    logic [7:0]  r_pa_out;
    logic [1:0]  r_status;
    logic        r_timeout_err;
    logic [7:0]  r_fifo [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;

    logic        w_rx_start;
    logic        w_tx_start;
    logic        w_timeout_hit;
    logic        w_ack_n;
    logic        w_pa_oe;
    logic        w_tx_ready;
    logic        w_fifo_full;
    logic        w_rx_valid;
    logic        w_push;
    logic        w_pop;

    assign w_fifo_full = (r_count == 3'd4);
    assign w_rx_valid  = (r_count != 3'd0);
    assign w_push      = w_rx_start;
    assign w_pop       = w_rx_valid & rx_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_wait_high blocks a second transfer until dav has been seen high again
    always_comb begin
        w_state_next  = r_state;
        w_rx_start    = 1'b0;
        w_tx_start    = 1'b0;
        w_timeout_hit = 1'b0;
        w_ack_n       = 1'b1;
        w_pa_oe       = 1'b0;
        w_tx_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_dav_s && !r_wait_high) begin
                    if (!dir) begin
                        if (!w_fifo_full) begin
                            w_rx_start   = 1'b1;
                            w_state_next = S_HOLD;
                        end
                    end else if (tx_valid) begin
                        w_tx_start   = 1'b1;
                        w_tx_ready   = 1'b1;
                        w_state_next = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                w_pa_oe = r_dir;
                if (r_setup_cnt == c_setup_last) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                w_ack_n = 1'b0;
                w_pa_oe = r_dir;
                if (r_dav_s) begin
                    w_state_next = S_RELEASE;
                end else if (r_hold_cnt == c_timeout_last) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dav_meta    <= 1'b1;
            r_dav_s       <= 1'b1;
            r_pa_meta     <= 8'h00;
            r_pa_s        <= 8'h00;
            r_dir         <= 1'b0;
            r_setup_cnt   <= 4'd0;
            r_hold_cnt    <= 16'd0;
            r_wait_high   <= 1'b0;
            r_pa_out      <= 8'h00;
            r_status      <= 2'b00;
            r_timeout_err <= 1'b0;
            r_wr_ptr      <= 2'd0;
            r_rd_ptr      <= 2'd0;
            r_count       <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_fifo[i] <= 8'h00;
            end
        end else begin
            r_dav_meta <= dav_n;
            r_dav_s    <= r_dav_meta;
            r_pa_meta  <= pa_in;
            r_pa_s     <= r_pa_meta;

            if (w_rx_start || w_tx_start) begin
                r_dir       <= dir;
                r_wait_high <= 1'b1;
            end else if (r_dav_s) begin
                r_wait_high <= 1'b0;
            end

            r_setup_cnt <= (r_state == S_SETUP) ? r_setup_cnt + 4'd1 : 4'd0;
            r_hold_cnt  <= (r_state == S_HOLD) ? r_hold_cnt + 16'd1 : 16'd0;

            if (w_tx_start) begin
                r_pa_out <= tx_data;
                r_status <= tx_status;
            end else if (w_rx_start) begin
                r_status <= 2'b00;
            end else if (w_timeout_hit) begin
                r_status      <= 2'b10;
                r_timeout_err <= 1'b1;
            end

            if (w_push) begin
                r_fifo[r_wr_ptr] <= r_pa_s;
                r_wr_ptr         <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign ack_n       = w_ack_n;
    assign pa_oe       = w_pa_oe;
    assign tx_ready    = w_tx_ready;
    assign pa_out      = r_pa_out;
    assign status      = r_status;
    assign timeout_err = r_timeout_err;
    assign rx_valid    = w_rx_valid;
    assign rx_data     = r_fifo[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_tcbm_device_link.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcbm_device_link
// Brief    : Directed bench for tcbm_device_link with a transfer-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tcbm_device_link;

    localparam int SETUP = 2;
    localparam int TMO   = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       dav_n;
    logic       ack_n;
    logic [7:0] pa_in;
    logic [7:0] pa_out;
    logic       pa_oe;
    logic [1:0] status;
    logic       dir;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic [1:0] tx_status;
    logic       tx_valid;
    logic       tx_ready;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    int tx_pulses = 0;

    tcbm_device_link #(
        .SETUP_CYCLES(SETUP),
        .TIMEOUT     (TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .dav_n      (dav_n),
        .ack_n      (ack_n),
        .pa_in      (pa_in),
        .pa_out     (pa_out),
        .pa_oe      (pa_oe),
        .status     (status),
        .dir        (dir),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_status  (tx_status),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transfer-level model: a transfer is either idle or an active byte
    // transfer with a remaining setup time, a hold duration and a release beat.
    bit         m_live = 1'b0;
    bit         h0, h1;
    logic [7:0] p0, p1;
    logic [7:0] q[$];
    bit         m_active, m_rel, m_tx, need_high, m_err;
    int         setup_left, hold_clocks;
    logic [1:0] m_status;
    logic [7:0] m_pa_out;

    task automatic begin_xfer(input bit is_tx);
        m_active    = 1'b1;
        m_rel       = 1'b0;
        m_tx        = is_tx;
        hold_clocks = 0;
        setup_left  = is_tx ? SETUP : 0;
        need_high   = 1'b1;
    endtask

    task automatic model_step();
        bit         ds;
        bit         do_pop;
        bit         full;
        logic [7:0] ps;
        if (reset) begin
            h0 = 1'b1; h1 = 1'b1; p0 = 8'h00; p1 = 8'h00;
            q.delete();
            m_active = 1'b0; m_rel = 1'b0; m_tx = 1'b0; need_high = 1'b0;
            setup_left = 0; hold_clocks = 0;
            m_status = 2'b00; m_err = 1'b0; m_pa_out = 8'h00;
            m_live = 1'b1;
            return;
        end
        ds     = h1;
        ps     = p1;
        do_pop = (q.size() > 0) && rx_ready;
        full   = (q.size() == 4);
        if (!m_active) begin
            if (!ds && !need_high) begin
                if (!dir && !full) begin
                    q.push_back(ps);
                    begin_xfer(1'b0);
                    m_status = 2'b00;
                end else if (dir && tx_valid) begin
                    begin_xfer(1'b1);
                    m_pa_out = tx_data;
                    m_status = tx_status;
                end
            end
        end else if (m_rel) begin
            m_active = 1'b0;
            m_rel    = 1'b0;
        end else if (setup_left > 0) begin
            setup_left--;
        end else if (ds) begin
            m_rel = 1'b1;
        end else if (hold_clocks == TMO - 1) begin
            m_rel    = 1'b1;
            m_err    = 1'b1;
            m_status = 2'b10;
        end else begin
            hold_clocks++;
        end
        if (do_pop) void'(q.pop_front());
        if (ds) need_high = 1'b0;
        h1 = h0; h0 = dav_n; p1 = p0; p0 = pa_in;
    endtask

    always @(posedge clock) begin
        bit e_ack_n, e_pa_oe, e_tx_ready;
        model_step();
        #1;
        if (m_live) begin
            e_ack_n    = !(m_active && !m_rel && setup_left == 0);
            e_pa_oe    = m_active && !m_rel && m_tx;
            e_tx_ready = !m_active && !h1 && !need_high && dir && tx_valid;
            check("m_ack_n", 16'(ack_n), 16'(e_ack_n));
            check("m_pa_oe", 16'(pa_oe), 16'(e_pa_oe));
            check("m_pa_out", 16'(pa_out), 16'(m_pa_out));
            check("m_status", 16'(status), 16'(m_status));
            check("m_timeout_err", 16'(timeout_err), 16'(m_err));
            check("m_tx_ready", 16'(tx_ready), 16'(e_tx_ready));
            check("m_rx_valid", 16'(rx_valid), 16'(q.size() != 0));
            if (q.size() != 0) check("m_rx_data", 16'(rx_data), 16'(q[0]));
        end
    end

    always @(negedge clock) begin
        if (tx_ready === 1'b1) tx_pulses++;
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic wait_ack(input logic lvl, input int budget, input string nm);
        int n;
        n = 0;
        while (ack_n !== lvl && n < budget) begin
            @(posedge clock);
            #2;
            n++;
        end
        check(nm, 16'(ack_n), 16'(lvl));
    endtask

    task automatic rx_byte(input logic [7:0] b, input string nm);
        @(negedge clock);
        dir = 1'b0; pa_in = b; dav_n = 1'b0;
        wait_ack(1'b0, 12, nm);
        @(negedge clock);
        dav_n = 1'b1;
        wait_ack(1'b1, 6, nm);
        edges(2);
    endtask

    task automatic pop_expect(input logic [7:0] exp, input string nm);
        @(negedge clock);
        check(nm, 16'(rx_valid), 16'(1'b1));
        check(nm, 16'(rx_data), 16'(exp));
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] bp_exp [4];
        bp_exp[0] = 8'h02; bp_exp[1] = 8'h03; bp_exp[2] = 8'h04; bp_exp[3] = 8'h05;

        reset = 1'b1; dav_n = 1'b1; dir = 1'b0; pa_in = 8'h00; rx_ready = 1'b0;
        tx_data = 8'h00; tx_status = 2'b00; tx_valid = 1'b0;

        // Reset state
        edges(3);
        check("rst_ack_n", 16'(ack_n), 16'(1'b1));
        check("rst_pa_oe", 16'(pa_oe), 16'(1'b0));
        check("rst_pa_out", 16'(pa_out), 16'h0000);
        check("rst_status", 16'(status), 16'h0000);
        check("rst_rx_valid", 16'(rx_valid), 16'(1'b0));
        check("rst_tx_ready", 16'(tx_ready), 16'(1'b0));
        check("rst_timeout_err", 16'(timeout_err), 16'(1'b0));
        @(negedge clock);
        reset = 1'b0;
        edges(2);

        // Receive A5 with exact latency
        @(negedge clock);
        dir = 1'b0; pa_in = 8'hA5; dav_n = 1'b0;
        edges(2);
        check("rx_ack_before", 16'(ack_n), 16'(1'b1));
        edges(1);
        check("rx_ack_k2", 16'(ack_n), 16'(1'b0));
        check("rx_valid_a5", 16'(rx_valid), 16'(1'b1));
        check("rx_data_a5", 16'(rx_data), 16'h00A5);
        @(negedge clock);
        dav_n = 1'b1;
        wait_ack(1'b1, 3, "rx_release");
        edges(2);
        pop_expect(8'hA5, "rx_pop_a5");

        // Backpressure on a full FIFO
        rx_byte(8'h01, "bp_b1");
        rx_byte(8'h02, "bp_b2");
        rx_byte(8'h03, "bp_b3");
        rx_byte(8'h04, "bp_b4");
        @(negedge clock);
        pa_in = 8'h05; dav_n = 1'b0;
        edges(8);
        check("bp_hold_ack", 16'(ack_n), 16'(1'b1));
        check("bp_head", 16'(rx_data), 16'h0001);
        @(negedge clock);
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
        wait_ack(1'b0, 6, "bp_accept");
        @(negedge clock);
        dav_n = 1'b1;
        wait_ack(1'b1, 6, "bp_release");
        for (int i = 0; i < 4; i++) pop_expect(bp_exp[i], "bp_pop");
        @(negedge clock);
        check("bp_empty", 16'(rx_valid), 16'(1'b0));

        // Transmit 3C with setup, and dir toggled during HOLD
        tx_pulses = 0;
        @(negedge clock);
        dir = 1'b1; tx_data = 8'h3C; tx_status = 2'b01; tx_valid = 1'b1; dav_n = 1'b0;
        edges(3);
        check("tx_pa_oe", 16'(pa_oe), 16'(1'b1));
        check("tx_pa_out", 16'(pa_out), 16'h003C);
        check("tx_status", 16'(status), 16'h0001);
        check("tx_ack_setup", 16'(ack_n), 16'(1'b1));
        edges(1);
        check("tx_ack_k3", 16'(ack_n), 16'(1'b1));
        edges(1);
        check("tx_ack_k4", 16'(ack_n), 16'(1'b0));
        @(negedge clock);
        dir = 1'b0;
        edges(2);
        check("tx_dir_toggle_oe", 16'(pa_oe), 16'(1'b1));
        @(negedge clock);
        dav_n = 1'b1;
        wait_ack(1'b1, 6, "tx_release");
        check("tx_release_oe", 16'(pa_oe), 16'(1'b0));
        edges(2);
        check("tx_ready_pulses", 16'(tx_pulses), 16'd1);
        @(negedge clock);
        tx_valid = 1'b0;

        // Timeout with dav held low
        @(negedge clock);
        dir = 1'b0; pa_in = 8'h77; dav_n = 1'b0;
        wait_ack(1'b0, 10, "to_accept");
        edges(TMO - 1);
        check("to_hold_last", 16'(ack_n), 16'(1'b0));
        check("to_err_early", 16'(timeout_err), 16'(1'b0));
        edges(1);
        check("to_err", 16'(timeout_err), 16'(1'b1));
        check("to_status", 16'(status), 16'h0002);
        check("to_ack_n", 16'(ack_n), 16'(1'b1));
        edges(8);
        check("to_no_retrigger", 16'(ack_n), 16'(1'b1));
        check("to_one_byte", 16'(rx_data), 16'h0077);
        @(negedge clock);
        dav_n = 1'b1;
        edges(3);
        @(negedge clock);
        pa_in = 8'h88; dav_n = 1'b0;
        wait_ack(1'b0, 10, "to_retry");
        check("to_status_clear", 16'(status), 16'h0000);
        check("to_err_sticky", 16'(timeout_err), 16'(1'b1));
        @(negedge clock);
        dav_n = 1'b1;
        wait_ack(1'b1, 6, "to_retry_release");
        edges(2);
        pop_expect(8'h77, "to_pop_77");

        // Reset while a transmit is in HOLD, then restart on still-low dav
        @(negedge clock);
        dir = 1'b1; tx_data = 8'h5A; tx_status = 2'b11; tx_valid = 1'b1; dav_n = 1'b0;
        wait_ack(1'b0, 12, "rst_tx_hold");
        @(negedge clock);
        reset = 1'b1;
        edges(1);
        check("rst_mid_ack_n", 16'(ack_n), 16'(1'b1));
        check("rst_mid_pa_oe", 16'(pa_oe), 16'(1'b0));
        check("rst_mid_rx_valid", 16'(rx_valid), 16'(1'b0));
        check("rst_mid_err", 16'(timeout_err), 16'(1'b0));
        @(negedge clock);
        reset = 1'b0;
        wait_ack(1'b0, 12, "rst_restart");
        check("rst_restart_pa_out", 16'(pa_out), 16'h005A);
        check("rst_restart_status", 16'(status), 16'h0003);
        @(negedge clock);
        dav_n = 1'b1; tx_valid = 1'b0;
        wait_ack(1'b1, 6, "rst_restart_release");
        edges(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/tcbm_device_link.md
TCBM_DEVICE_LINK -- requirements
Module: tcbm_device_link

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 2: clocks pa_out is driven before ack_n asserts on a device->host byte; legal 1..15.
REQ-002 SHALL have parameter TIMEOUT, default 65535: max clocks in HOLD before abort; 16-bit counter.
REQ-003 SHALL have port clock  in  1  sole clock; all flops rising-edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port dav_n  in  1  host data-valid strobe (host port C bit 6), asynchronous, active-low.
REQ-006 SHALL have port ack_n  out  1  acknowledge to host (host port C bit 7), active-low.
REQ-007 SHALL have port pa_in  in  8  port A bus as seen from device side, asynchronous.
REQ-008 SHALL have ports pa_out  out  8 and pa_oe  out  1: device drive value and enable for port A.
REQ-009 SHALL have port status  out  2  status lines to host port B[1:0].
REQ-010 SHALL have port dir  in  1  0 = host->device, 1 = device->host; sampled only in IDLE.
REQ-011 SHALL have ports rx_data  out  8, rx_valid  out  1, rx_ready  in  1: receive FIFO head, valid/ready.
REQ-012 SHALL have ports tx_data  in  8, tx_status  in  2, tx_valid  in  1, tx_ready  out  1: transmit byte offer.
REQ-013 SHALL have port timeout_err  out  1  sticky abort flag.

Function
REQ-014 SHALL pass dav_n through a 2-flop synchronizer (dav_s) and pa_in through a matching 2-flop register (pa_s); no other logic sees the raw pins.
REQ-015 SHALL implement FSM states IDLE, SETUP, HOLD, RELEASE.
REQ-016 IDLE: ack_n=1, pa_oe=0; dir latched into dir_r on the IDLE->next transition; dir changes at other times ignored.
REQ-017 IDLE, dav_s=0, dir=0, FIFO not full: SHALL push pa_s into FIFO and go HOLD; ack_n=0 and status=2'b00 from the same edge.
REQ-018 IDLE, dav_s=0, dir=0, FIFO full: SHALL stay IDLE with ack_n=1 (backpressure), no data loss.
REQ-019 IDLE, dav_s=0, dir=1, tx_valid=1: SHALL load pa_out=tx_data, status=tx_status, pa_oe=1, pulse tx_ready for exactly one clock, go SETUP.
REQ-020 IDLE, dav_s=0, dir=1, tx_valid=0: SHALL stay IDLE, ack_n=1, tx_ready=0.
REQ-021 SETUP: SHALL hold pa_out/pa_oe for SETUP_CYCLES clocks, then go HOLD with ack_n=0.
REQ-022 HOLD: ack_n=0; on dav_s=1 SHALL go RELEASE; counter increments each HOLD clock.
REQ-023 RELEASE: SHALL drive ack_n=1, pa_oe=0 for one clock, then IDLE; the same dav low phase SHALL never produce a second transfer.
REQ-024 Latency: dav_n first sampled low at edge k -> rx: ack_n low after edge k+2; tx: pa_oe high after edge k+2, ack_n low after edge k+2+SETUP_CYCLES.
REQ-025 Timeout: HOLD counter reaching TIMEOUT SHALL set timeout_err=1, status=2'b10, go RELEASE; then wait dav_s=1 in IDLE before accepting a new transfer.
REQ-026 status SHALL hold its last value outside transfers; 2'b10 after timeout until the next successful transfer.
REQ-027 FIFO: depth 4, 2-bit pointers, 3-bit count; rx_valid=(count!=0), rx_data=head, combinational from registers.
REQ-028 Pop when rx_valid&rx_ready; push per REQ-017; simultaneous push and pop SHALL keep count unchanged; full evaluated before that cycle's pop.
REQ-029 Pointers SHALL wrap 3->0; count SHALL never exceed 4 or go below 0.

Reset
REQ-030 reset=1 at an edge SHALL force: IDLE, ack_n=1, pa_oe=0, pa_out=8'h00, status=2'b00, tx_ready=0, FIFO empty, timeout_err=0, counters 0, synchronizers to 1 (dav) / 8'h00 (pa).
REQ-031 Reset mid-transfer SHALL release ack_n and pa_oe at that edge; after reset, a still-low dav_n SHALL start a new transfer normally.

Verification
REQ-032 Rx: dir=0, pa_in=8'hA5, dav_n low at k -> ack_n low after k+2, rx_valid=1, rx_data=8'hA5; dav_n high -> ack_n high within 3 clocks.
REQ-033 Backpressure: 4 rx bytes 01..04 with rx_ready=0, 5th dav_n low -> ack_n stays 1; one pop -> 5th byte 05 accepted; pops yield 02,03,04,05 in order.
REQ-034 Tx: dir=1, tx_data=8'h3C, tx_status=2'b01, tx_valid=1, dav_n low at k -> pa_oe=1, pa_out=8'h3C after k+2, ack_n low after k+4, tx_ready exactly one pulse.
REQ-035 Timeout: TIMEOUT=16, dav_n held low -> after 16 HOLD clocks timeout_err=1, status=2'b10, ack_n=1; no new transfer until dav_n goes high then low.
REQ-036 Reset in HOLD (tx): reset pulse -> ack_n=1, pa_oe=0, rx_valid=0 next edge; dir toggled during HOLD without reset -> transfer completes per original direction.
